// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter (package mult_pkg).
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Index reached by stepping 'offset' places past 'last' in a ring of n requesters.
    function automatic int rr_next(input int last, input int offset, input int n);
        return (last + offset) % n;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester after last_grant_i, wrapping.
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_valid_o
);

    always_comb begin
        int idx;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = rr_next(int'(last_grant_i), k, NUM_REQ);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential signed multiplier among NUM_REQ requesters, round-robin.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips the core and answers 0 directly.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int ID_W    = 1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_start,
    input  logic                     mul_done,
    input  logic [2*WIDTH-2:0]       mul_product,
    input  logic                     mul_sign,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-2:0]       rsp_product,
    output logic                     rsp_sign,
    output logic                     busy,
    output state_e                   dbg_state_o
);

    localparam int PW = 2*WIDTH-1;

    state_e            state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [WIDTH-1:0]  mul_a_q;
    logic [WIDTH-1:0]  mul_b_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [PW-1:0]     rsp_product_q;
    logic              rsp_sign_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic [WIDTH-1:0]   op_a_d;
    logic [WIDTH-1:0]   op_b_d;
    logic               rsp_sign_d;
    logic               zero_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        op_a_d = '0;
        op_b_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_a_d = req_a[i*WIDTH +: WIDTH];
                op_b_d = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // A zero magnitude is always reported as positive.
    assign rsp_sign_d = mul_sign && (mul_product != '0);

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_op = (op_a_d == '0) || (op_b_d == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= ID_W'(NUM_REQ-1);
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            rsp_sign_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mul_a_q      <= op_a_d;
                        mul_b_q      <= op_b_d;
                        rsp_id_q     <= grant_idx;
                        last_grant_q <= grant_idx;
                        if (zero_op) begin
                            rsp_product_q <= '0;
                            rsp_sign_q    <= 1'b0;
                            state_q       <= ST_RESPOND;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_BUSY;
                ST_BUSY: begin
                    if (mul_done) begin
                        rsp_product_q <= mul_product;
                        rsp_sign_q    <= rsp_sign_d;
                        state_q       <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshakes: a request transfers when req_valid[i] && req_ready[i] at a rising edge,
    // a response when rsp_valid && rsp_ready; each side holds its payload until then.
    assign req_ready   = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign mul_start   = (state_q == ST_ISSUE);
    assign rsp_valid   = (state_q == ST_RESPOND);
    assign busy        = (state_q != ST_IDLE);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_sign    = rsp_sign_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: requester driver, multiplier core model, scoreboard monitor.
module tb_mult_share_arbiter;
    import mult_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;
    localparam int PW      = 2*WIDTH-1;
    localparam int RW      = ID_W+1+PW;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     sys_clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic                     mul_start;
    logic                     mul_done;
    logic [PW-1:0]            mul_product;
    logic                     mul_sign;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [PW-1:0]            rsp_product;
    logic                     rsp_sign;
    logic                     busy;
    state_e                   dbg_state;

    mult_share_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .ID_W    (ID_W)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .mul_sign    (mul_sign),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_sign    (rsp_sign),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- shared bench state ----------------
    int                 n_checks = 0;
    int                 n_pass   = 0;
    logic [RW-1:0]      exp_q[$];
    int                 grant_log[$];
    logic [NUM_REQ-1:0] accepted = '0;
    logic [NUM_REQ-1:0] keep     = '0;
    bit                 rand_en  = 1'b0;
    bit                 spur_en  = 1'b0;
    int                 rsp_mode = 0;
    int                 lat_fixed = 0;
    int                 start_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Reference: signed product as {id, sign, magnitude}; zero is never negative.
    function automatic logic [RW-1:0] model_rsp(input int id, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        int p;
        int m;
        p = int'($signed(a)) * int'($signed(b));
        m = (p < 0) ? -p : p;
        return {ID_W'(id), (p < 0), PW'(m)};
    endfunction

    // Round-robin reference: the valid requester at the smallest ring distance after last.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        int best;
        int best_d;
        int d;
        best = -1;
        best_d = NUM_REQ + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - last - 1 + 2*NUM_REQ) % NUM_REQ;
            if (v[i] && d < best_d) begin
                best = i;
                best_d = d;
            end
        end
        return best;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        if ($urandom_range(0, 7) == 0) return '0;
        return WIDTH'($urandom_range(0, 255));
    endfunction

    task automatic step();
        @(negedge sys_clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i]) begin
                accepted[i] = 1'b0;
                if (!keep[i]) req_valid[i] = 1'b0;
            end
        end
        if (rand_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) drive_req(i, rand_op(), rand_op());
                else if (req_valid[i] && $urandom_range(0, 29) == 0) req_valid[i] = 1'b0;
            end
        end
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic wait_quiet(input int max);
        int n;
        n = 0;
        step();
        while ((busy || exp_q.size() != 0 || req_valid != '0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) fail_now("timeout_quiet", "DUT or queue not idle, want idle");
    endtask

    // ---------------- multiplier core model ----------------
    initial begin
        int cnt;
        int p;
        logic [WIDTH-1:0] ca;
        logic [WIDTH-1:0] cb;
        cnt = 0;
        p = 0;
        ca = '0;
        cb = '0;
        mul_done = 1'b0;
        mul_product = '0;
        mul_sign = 1'b0;
        forever begin
            @(negedge sys_clk);
            mul_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    check("operands_stable", 64'({mul_a, mul_b}), 64'({ca, cb}));
                    p = int'($signed(ca)) * int'($signed(cb));
                    mul_product = PW'((p < 0) ? -p : p);
                    mul_sign = ca[WIDTH-1] ^ cb[WIDTH-1];
                    mul_done = 1'b1;
                end
            end else if (mul_start) begin
                ca = mul_a;
                cb = mul_b;
                cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
            end else if (spur_en && (!busy || rsp_valid) && $urandom_range(0, 4) == 0) begin
                mul_product = PW'($urandom);
                mul_sign = 1'b1;
                mul_done = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int last;
        int g;
        bit exp_issue;
        bit exp_byp;
        bit exp_rsp;
        bit prev_hold;
        bit prev_start;
        bit prev_hs;
        logic [RW-1:0]      held;
        logic [NUM_REQ-1:0] ev;
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        last = NUM_REQ-1;
        exp_issue = 0; exp_byp = 0; exp_rsp = 0;
        prev_hold = 0; prev_start = 0; prev_hs = 0;
        held = '0;
        forever begin
            @(negedge sys_clk);
            #2;
            if (rst) begin
                exp_q.delete();
                last = NUM_REQ-1;
                exp_issue = 0; exp_byp = 0; exp_rsp = 0;
                prev_hold = 0; prev_start = 0; prev_hs = 0;
                continue;
            end
            if (exp_issue) check("start_after_accept", 64'(mul_start), 64'(1));
            if (exp_byp) begin
                check("bypass_rsp_valid", 64'(rsp_valid), 64'(1));
                check("bypass_no_start", 64'(mul_start), 64'(0));
            end
            if (exp_rsp) check("rsp_after_done", 64'(rsp_valid), 64'(1));
            if (prev_start) check("start_one_cycle", 64'({mul_start, busy}), 64'(2'b01));
            if (prev_hold) begin
                check("rsp_hold_valid", 64'(rsp_valid), 64'(1));
                check("rsp_hold_data", 64'({rsp_id, rsp_sign, rsp_product}), 64'(held));
            end
            if (prev_hs) check("idle_after_rsp", 64'({rsp_valid, busy}), 64'(0));
            exp_issue = 0;
            exp_byp = 0;
            if (mul_start) start_cnt++;

            if (!busy) begin
                g = model_pick(req_valid, last);
                ev = '0;
                if (g >= 0) ev[g] = 1'b1;
                check("req_ready_grant", 64'(req_ready), 64'(ev));
                if (g >= 0) begin
                    a = req_a[g*WIDTH +: WIDTH];
                    b = req_b[g*WIDTH +: WIDTH];
                    exp_q.push_back(model_rsp(g, a, b));
                    grant_log.push_back(g);
                    last = g;
                    accepted[g] = 1'b1;
                    if (BYPASS && (a == '0 || b == '0)) exp_byp = 1;
                    else exp_issue = 1;
                end
            end else begin
                check("req_ready_busy", 64'(req_ready), 64'(0));
            end

            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_rsp", "response with empty queue, want none");
                else check("rsp", 64'({rsp_id, rsp_sign, rsp_product}), 64'(exp_q.pop_front()));
            end
            prev_hs    = rsp_valid && rsp_ready;
            prev_hold  = rsp_valid && !rsp_ready;
            held       = {rsp_id, rsp_sign, rsp_product};
            exp_rsp    = busy && !rsp_valid && !mul_start && mul_done;
            prev_start = mul_start;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        check("reset_ctrl", 64'({rsp_valid, busy, mul_start, req_ready}), 64'(0));
        check("reset_data", 64'({mul_a, mul_b, rsp_id, rsp_sign, rsp_product}), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        step();
        rst = 1'b0;

        // contention: two requesters held valid, expect alternation starting at 0
        lat_fixed = 3;
        keep = 3'b011;
        drive_req(0, 8'd2, 8'd3);
        drive_req(1, 8'hFC, 8'hFC);
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin step(); n++; end
        if (n >= 200) fail_now("timeout_contention", "fewer than 4 grants, want 4");
        keep = '0;
        req_valid = '0;
        wait_quiet(100);
        if (grant_log.size() >= 4) begin
            check("rr_order0", 64'(grant_log[0]), 64'(0));
            check("rr_order1", 64'(grant_log[1]), 64'(1));
            check("rr_order2", 64'(grant_log[2]), 64'(0));
            check("rr_order3", 64'(grant_log[3]), 64'(1));
        end

        // single request, 9-cycle core
        lat_fixed = 9;
        s0 = start_cnt;
        n = grant_log.size();
        drive_req(0, 8'hFD, 8'd5);
        wait_quiet(100);
        check("single_grant", 64'(grant_log.size()), 64'(n + 1));
        check("single_starts", 64'(start_cnt - s0), 64'(1));

        // backpressure with spurious done in RESPOND
        lat_fixed = 2;
        rsp_mode = 1;
        spur_en = 1'b1;
        drive_req(2, 8'd7, 8'hF7);
        n = 0;
        while (!rsp_valid && n < 100) begin step(); n++; end
        if (n >= 100) fail_now("timeout_bp", "no rsp_valid, want rsp_valid");
        drive_req(0, 8'd1, 8'd1);
        n = grant_log.size();
        repeat (20) step();
        check("bp_no_grant", 64'(grant_log.size()), 64'(n));
        rsp_mode = 0;
        step();
        step();
        #3;
        check("bp_next_grant", 64'(grant_log.size()), 64'(n + 1));
        wait_quiet(100);

        // spurious done in IDLE
        repeat (10) step();
        check("spur_idle", 64'({busy, rsp_valid}), 64'(0));
        spur_en = 1'b0;

        // zero operand
        s0 = start_cnt;
        drive_req(1, 8'd0, 8'hF9);
        wait_quiet(100);
        check("zero_starts", 64'(start_cnt - s0), BYPASS ? 64'(0) : 64'(1));

        // reset in BUSY, then requester 0 must win again
        lat_fixed = 12;
        drive_req(0, 8'd9, 8'd9);
        n = 0;
        step();
        while (!(busy && !mul_start && !rsp_valid) && n < 50) begin step(); n++; end
        if (n >= 50) fail_now("timeout_busy", "never reached BUSY, want BUSY");
        step();
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("rst_busy_ctrl", 64'({busy, rsp_valid, mul_start}), 64'(0));
        check("rst_busy_data", 64'({mul_a, rsp_product, rsp_sign}), 64'(0));
        step();
        step();
        rst = 1'b0;
        lat_fixed = 0;
        n = grant_log.size();
        drive_req(0, 8'd3, 8'd4);
        drive_req(1, 8'd5, 8'd6);
        wait_quiet(100);
        if (grant_log.size() > n) check("rst_first_grant", 64'(grant_log[n]), 64'(0));
        else fail_now("rst_first_grant", "no grant after reset, want requester 0");

        // randomized traffic
        rsp_mode = 2;
        spur_en = 1'b1;
        rand_en = 1'b1;
        repeat (400) step();
        rand_en = 1'b0;
        req_valid = '0;
        rsp_mode = 0;
        spur_en = 1'b0;
        wait_quiet(300);
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one sequential signed multiplier core among NUM_REQ requesters.
- Sits between requester logic (button-driven operand capture, test pattern source, etc.) and the multiplier datapath/control pair.
- Accepts one operand pair at a time, issues a start pulse, waits for done, and returns the sign-magnitude product tagged with the requester index.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 8, operand width in bits (signed two's complement).
- ID_W, 1, width of requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  packed multipliers; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed multiplicands, same packing.
- mul_a  out  WIDTH  operand A to core; stable from ISSUE through BUSY.
- mul_b  out  WIDTH  operand B to core; stable from ISSUE through BUSY.
- mul_start  out  1  one-cycle start pulse to core.
- mul_done  in  1  core completion pulse.
- mul_product  in  2*WIDTH-1  core product magnitude, valid with mul_done.
- mul_sign  in  1  core product sign, valid with mul_done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_product  out  2*WIDTH-1  latched magnitude.
- rsp_sign  out  1  latched sign.
- busy  out  1  high in any state other than IDLE (drives status LED).

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, BUSY, RESPOND.
- IDLE:
  - If any req_valid is high, select grant g = first valid index searching last_grant+1 upward, wrapping modulo NUM_REQ.
  - req_ready[g] is combinationally high this cycle, and the handshake completes.
  - Latch req_a/req_b of g into mul_a/mul_b, latch g into rsp_id and last_grant, then go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle, then go to BUSY.
- BUSY:
  - Wait for mul_done. On mul_done, capture mul_product/mul_sign into rsp_product/rsp_sign and go to RESPOND.
  - No timeout.
- RESPOND:
  - rsp_valid=1 and all rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. rsp_valid drops the next cycle.
  - The next grant cannot occur before that IDLE cycle, so there is one idle bubble.
- Latency: accept at cycle 0, mul_start at cycle 1, mul_done at cycle k, rsp_valid from cycle k+1.
- req_ready is 0 in every state except IDLE. Requests arriving during an operation wait; they are not queued.
- mul_done in IDLE, ISSUE or RESPOND is ignored.
- rsp_ready outside RESPOND is ignored.
- A requester that drops req_valid before being granted is simply skipped.
- Simultaneous valids are resolved strictly round-robin. The granted index becomes lowest priority for the next arbitration.
- Reset asserted mid-operation: return immediately to IDLE, clear all outputs and reset the pointer. The multiplier core is reset by the same rst.
- rsp_sign is forced to 0 when rsp_product is 0 (no "-0" on the display).

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted req_a or req_b equals 0, skip ISSUE/BUSY.
  - Go directly to RESPOND next cycle with rsp_product=0, rsp_sign=0.
  - No mul_start is issued. Latency is 1 cycle.
- Undefined: zero operands follow the normal ISSUE/BUSY path.

Decomposition:
- Package mult_pkg holds:
  - FSM state enum (IDLE, ISSUE, BUSY, RESPOND, 2-bit encoding).
  - Default WIDTH constant.
  - Helper function for the round-robin next-index computation.
- Sub-module rr_arbiter:
  - Combinational: req vector + last_grant in, one-hot grant + index out.
  - Parameterised by NUM_REQ.
- FSM and datapath latches stay in mult_share_arbiter.

Test Plan:
- Reset mid-BUSY: assert rst while in BUSY -> next edge state IDLE, busy=0, rsp_valid=0; requester 0 wins the next simultaneous request.
- Single request: requester 0 sends a=-3 (8'hFD), b=5; core model returns done after 9 cycles -> mul_start one cycle after accept, rsp_product=15, rsp_sign=1, rsp_id=0.
- Contention: both valid continuously with a=2,b=3 and a=-4,b=-4 -> grants alternate 0,1,0,1; responses 6/+ id0, 16/+ id1; req_ready never high in both bits or outside IDLE.
- Backpressure: hold rsp_ready=0 for 20 cycles in RESPOND -> rsp_* stable; no req_ready; after rsp_ready=1, next grant two cycles later.
- Spurious done: pulse mul_done in IDLE and RESPOND -> no state change, rsp values unchanged.
- Zero operand: a=0, b=-7 -> with MULT_ZERO_BYPASS_EN, rsp_valid one cycle after accept, no mul_start, product 0, sign 0; without it, normal path, sign forced 0.
